// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg / fetch_queue_if
//
// Purpose:
//   fetch_queue_pkg defines fetch_data_t, the per-instruction record that flows
//   from fetch to decode. fetch_queue_if bundles the push side (fetch) and the
//   pop side (decode) of the fetch queue into one port.
//
// Interface signals:
//   in_valid  [1:0]  push slot valid, in_valid[1] implies in_valid[0]
//   in_data   [1:0]  [0] = older instruction, [1] = younger
//   in_ready         1 when at least two entries are free
//   out_valid [1:0]  out_data[i] holds a live entry
//   out_data  [1:0]  [0] = oldest, [1] = next oldest
//   out_pop   [1:0]  decode consumes slot i, out_pop[1] implies out_pop[0]
//   count            number of occupied entries
//
// Modports:
//   master  fetch/decode side (drives in_valid, in_data, out_pop)
//   slave   the queue itself
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

    // One fetched instruction with its prediction and exception side info
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
        logic        pred;
        logic        exception_instr;
    } fetch_data_t;

endpackage

interface fetch_queue_if #(
    parameter int DEPTH = 8
);
    import fetch_queue_pkg::*;

    logic [1:0]                   in_valid;
    fetch_data_t [1:0]            in_data;
    logic                         in_ready;
    logic [1:0]                   out_valid;
    fetch_data_t [1:0]            out_data;
    logic [1:0]                   out_pop;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output in_valid,
        output in_data,
        output out_pop,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  count
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_pop,
        output in_ready,
        output out_valid,
        output out_data,
        output count
    );

endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Purpose:
//   Dual-issue instruction buffer between fetch and decode. Accepts up to two
//   instructions per cycle in program order and presents the two oldest
//   entries to the two decode slots. flush empties the queue in one cycle.
//
// Parameters:
//   DEPTH  entry count, power of 2, >= 4
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset (overrides flush)
//   flush  discard all entries, including this cycle's push
//   bus    fetch_queue_if.slave (push/pop handshake, see fetch_queue_if.sv)
//
// Configuration:
//   FETCH_QUEUE_BYPASS_EN  when defined, an empty queue forwards in_data
//                          combinationally to out_data; bypassed entries popped
//                          in the same cycle are never written. When undefined
//                          there is no path from in_* to out_*.
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    fetch_queue_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    fetch_data_t      mem_q [DEPTH];

    logic             inReady;
    logic [1:0]       qValid;
    fetch_data_t [1:0] qData;
    logic [1:0]       outValid;
    fetch_data_t [1:0] outData;

    logic [1:0]       popMask;
    logic [1:0]       numPush;
    logic [1:0]       numPop;
    logic [1:0]       wrCount;
    logic [1:0]       headInc;
    fetch_data_t      wrData0;
    fetch_data_t      wrData1;

    // Registered view of the queue. in_ready comes from count_q alone so
    // decode's pop never feeds back combinationally into fetch.
    always_comb begin
        inReady   = (count_q <= CW'(DEPTH - 2));
        qValid[0] = (count_q != '0);
        qValid[1] = (count_q >= CW'(2));
        qData[0]  = qValid[0] ? mem_q[head_q]           : '0;
        qData[1]  = qValid[1] ? mem_q[head_q + PW'(1)]  : '0;
    end

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypassActive;

    // An empty queue forwards the incoming bundle straight to decode so a
    // refill after a redirect costs no extra cycle. Suppressed under flush
    // because the bundle is being discarded.
    always_comb begin
        bypassActive = (count_q == '0) && (bus.in_valid != 2'b00) && !flush;
        outValid     = qValid;
        outData      = qData;
        if (bypassActive) begin
            outValid   = bus.in_valid;
            outData[0] = bus.in_valid[0] ? bus.in_data[0] : '0;
            outData[1] = bus.in_valid[1] ? bus.in_data[1] : '0;
        end
    end
`else
    // Outputs come from stored entries only, giving a one-cycle minimum
    // fill-to-output latency.
    always_comb begin
        outValid = qValid;
        outData  = qData;
    end
`endif

    // Work out how many entries are written and retired this cycle. Pops are
    // counted against what decode actually sees, so popping an invalid slot
    // does nothing.
    always_comb begin
        numPush = 2'd0;
        if (inReady && !flush) begin
            numPush = {1'b0, bus.in_valid[0]} + {1'b0, bus.in_valid[1]};
        end
        popMask = bus.out_pop & outValid;
        numPop  = {1'b0, popMask[0]} + {1'b0, popMask[1]};

        wrCount = numPush;
        headInc = numPop;
        wrData0 = bus.in_data[0];
        wrData1 = bus.in_data[1];
`ifdef FETCH_QUEUE_BYPASS_EN
        // Bypassed entries consumed this cycle never enter storage; the
        // survivors are written at tail, and head stays put because nothing
        // stored was retired.
        if (bypassActive) begin
            wrCount = numPush - numPop;
            headInc = 2'd0;
            if (numPop == 2'd1) begin
                wrData0 = bus.in_data[1];
            end
        end
`endif
        tail_d  = tail_q + PW'(wrCount);
        head_d  = head_q + PW'(headInc);
        count_d = count_q + CW'(wrCount) - CW'(headInc);
    end

    // Pointer and occupancy registers. reset and flush both return the queue
    // to its empty origin and drop any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; stale contents are hidden by count.
    // The older instruction lands at tail, the younger one right after it.
    always_ff @(posedge clk) begin
        if (wrCount != 2'd0) begin
            mem_q[tail_q] <= wrData0;
        end
        if (wrCount == 2'd2) begin
            mem_q[tail_q + PW'(1)] <= wrData1;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.out_data  = outData;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//
// Purpose:
//   Directed self-checking bench for fetch_queue (DEPTH = 8). Walks through
//   fill, back-pressure, wrap-around drain, simultaneous push/pop, flush,
//   mid-stream reset and the empty-queue bypass behaviour.
// -----------------------------------------------------------------------------
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic clk;
    logic reset;
    logic flush;
    int   checks;
    int   fails;

    fetch_queue_if #(.DEPTH(8)) bus ();

    fetch_queue #(.DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    // 10 time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decode must never pop the younger slot alone
    always @(negedge clk) begin
        if (!reset) begin
            assert (bus.out_pop !== 2'b10)
                else $error("[TB] FAIL pop_order observed=%b required=not 10", bus.out_pop);
        end
    end

    // Distinct, recognisable instruction record n
    function automatic fetch_data_t mk(input int n);
        fetch_data_t d;
        d.instr           = 32'hA000_0000 + 32'(n);
        d.pc              = 32'h0000_1000 + 32'(n * 4);
        d.pcplus4         = d.pc + 32'd4;
        d.pred            = n[0];
        d.exception_instr = n[1];
        return d;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected)
            else begin
                fails++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            end
    endtask

    task automatic driveInputs(input logic [1:0] valid, input fetch_data_t d0,
                               input fetch_data_t d1, input logic [1:0] pop,
                               input logic fl);
        bus.in_valid   = valid;
        bus.in_data[0] = d0;
        bus.in_data[1] = d1;
        bus.out_pop    = pop;
        flush          = fl;
        #1;
    endtask

    // Hold the given inputs across one posedge, then return to idle
    task automatic applyStimulus(input logic [1:0] valid, input fetch_data_t d0,
                                 input fetch_data_t d1, input logic [1:0] pop,
                                 input logic fl);
        driveInputs(valid, d0, d1, pop, fl);
        @(posedge clk);
        #1;
        driveInputs(2'b00, '0, '0, 2'b00, 1'b0);
    endtask

    task automatic checkState(input string tag, input int cnt,
                              input logic [1:0] valid, input logic ready);
        checkOutput({tag, "_count"},     128'(bus.count),     128'(cnt));
        checkOutput({tag, "_out_valid"}, 128'(bus.out_valid), 128'(valid));
        checkOutput({tag, "_in_ready"},  128'(bus.in_ready),  128'(ready));
    endtask

    task automatic checkData(input string tag, input fetch_data_t e0,
                             input fetch_data_t e1);
        checkOutput({tag, "_data0"}, 128'(bus.out_data[0]), 128'(e0));
        checkOutput({tag, "_data1"}, 128'(bus.out_data[1]), 128'(e1));
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        reset  = 1'b1;
        flush  = 1'b0;
        bus.in_valid = 2'b00;
        bus.in_data  = '0;
        bus.out_pop  = 2'b00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkState("reset", 0, 2'b00, 1'b1);
        checkData("reset", '0, '0);

        // Test 1: push two, no pop
        applyStimulus(2'b11, mk(0), mk(1), 2'b00, 1'b0);
        checkState("t1", 2, 2'b11, 1'b1);
        checkData("t1", mk(0), mk(1));
        checkOutput("t1_pcplus4_0", 128'(bus.out_data[0].pcplus4), 128'(32'h0000_1004));
        checkOutput("t1_pcplus4_1", 128'(bus.out_data[1].pcplus4), 128'(32'h0000_1008));

        // Single pop leaves one entry; the invalid slot reads as zero
        applyStimulus(2'b00, '0, '0, 2'b01, 1'b0);
        checkState("pop1", 1, 2'b01, 1'b1);
        checkData("pop1", mk(1), '0);

        // Test 2: push two per cycle, counts 3, 5, 7
        applyStimulus(2'b11, mk(2), mk(3), 2'b00, 1'b0);
        checkState("t2_c3", 3, 2'b11, 1'b1);
        applyStimulus(2'b11, mk(4), mk(5), 2'b00, 1'b0);
        checkState("t2_c5", 5, 2'b11, 1'b1);
        applyStimulus(2'b11, mk(6), mk(7), 2'b00, 1'b0);
        checkState("t2_c7", 7, 2'b11, 1'b0);
        // Push while not ready is dropped
        applyStimulus(2'b11, mk(90), mk(91), 2'b00, 1'b0);
        checkState("t2_c7_hold", 7, 2'b11, 1'b0);
        checkData("t2_c7_hold", mk(1), mk(2));
        // Pop one to reach 6, then push two to reach full
        applyStimulus(2'b00, '0, '0, 2'b01, 1'b0);
        checkState("t2_c6", 6, 2'b11, 1'b1);
        applyStimulus(2'b11, mk(8), mk(9), 2'b00, 1'b0);
        checkState("t2_full", 8, 2'b11, 1'b0);
        applyStimulus(2'b11, mk(92), mk(93), 2'b00, 1'b0);
        checkState("t2_full_hold", 8, 2'b11, 1'b0);

        // Test 3: drain the full queue two at a time across the wrap
        checkData("t3_d0", mk(2), mk(3));
        applyStimulus(2'b00, '0, '0, 2'b11, 1'b0);
        checkData("t3_d1", mk(4), mk(5));
        checkOutput("t3_d1_count", 128'(bus.count), 128'(6));
        applyStimulus(2'b00, '0, '0, 2'b11, 1'b0);
        checkData("t3_d2", mk(6), mk(7));
        applyStimulus(2'b00, '0, '0, 2'b11, 1'b0);
        checkData("t3_d3", mk(8), mk(9));
        applyStimulus(2'b00, '0, '0, 2'b11, 1'b0);
        checkState("t3_empty", 0, 2'b00, 1'b1);
        checkData("t3_empty", '0, '0);

        // Test 4: reach count 3 (single push uses slot 0 only), then push 2 + pop 1
        applyStimulus(2'b11, mk(20), mk(21), 2'b00, 1'b0);
        applyStimulus(2'b01, mk(22), mk(99), 2'b00, 1'b0);
        checkState("t4_c3", 3, 2'b11, 1'b1);
        applyStimulus(2'b11, mk(23), mk(24), 2'b01, 1'b0);
        checkState("t4_c4", 4, 2'b11, 1'b1);
        checkData("t4_c4", mk(21), mk(22));
        applyStimulus(2'b00, '0, '0, 2'b11, 1'b0);
        checkData("t4_c2", mk(23), mk(24));
        // Head lands on the last slot, so slot 1 reads from wrapped index 0
        applyStimulus(2'b11, mk(25), mk(26), 2'b11, 1'b0);
        checkState("t4_wrap", 2, 2'b11, 1'b1);
        checkData("t4_wrap", mk(25), mk(26));

        // Test 5: count 5, then flush with push and pop asserted
        applyStimulus(2'b11, mk(27), mk(28), 2'b00, 1'b0);
        applyStimulus(2'b01, mk(29), '0, 2'b00, 1'b0);
        checkOutput("t5_c5", 128'(bus.count), 128'(5));
        applyStimulus(2'b11, mk(30), mk(31), 2'b11, 1'b1);
        checkState("t5_flush", 0, 2'b00, 1'b1);
        checkData("t5_flush", '0, '0);

        // Mid-stream reset discards entries; next push becomes the head
        applyStimulus(2'b11, mk(32), mk(33), 2'b00, 1'b0);
        checkOutput("rst_pre", 128'(bus.count), 128'(2));
        reset = 1'b1;
        applyStimulus(2'b11, mk(34), mk(35), 2'b00, 1'b1);
        reset = 1'b0;
        #1;
        checkState("rst_mid", 0, 2'b00, 1'b1);
        applyStimulus(2'b01, mk(36), '0, 2'b00, 1'b0);
        checkState("rst_next", 1, 2'b01, 1'b1);
        checkData("rst_next", mk(36), '0);
        // Popping the invalid slot is ignored
        applyStimulus(2'b00, '0, '0, 2'b11, 1'b0);
        checkState("pop_invalid", 0, 2'b00, 1'b1);

        // Test 6: empty queue, push 2 and pop 1 in the same cycle
        driveInputs(2'b11, mk(40), mk(41), 2'b01, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
        checkOutput("t6_same_valid", 128'(bus.out_valid), 128'(2'b11));
        checkData("t6_same", mk(40), mk(41));
`else
        checkOutput("t6_same_valid", 128'(bus.out_valid), 128'(2'b00));
        checkData("t6_same", '0, '0);
`endif
        @(posedge clk);
        #1;
        driveInputs(2'b00, '0, '0, 2'b00, 1'b0);
`ifdef FETCH_QUEUE_BYPASS_EN
        checkState("t6_next", 1, 2'b01, 1'b1);
        checkData("t6_next", mk(41), '0);
`else
        checkState("t6_next", 2, 2'b11, 1'b1);
        checkData("t6_next", mk(40), mk(41));
`endif
        applyStimulus(2'b00, '0, '0, 2'b11, 1'b0);
        checkState("t6_drain", 0, 2'b00, 1'b1);

        // Flush on an empty queue suppresses any forwarding of the bundle
        driveInputs(2'b11, mk(50), mk(51), 2'b00, 1'b1);
        checkOutput("flush_nobypass", 128'(bus.out_valid), 128'(2'b00));
        @(posedge clk);
        #1;
        driveInputs(2'b00, '0, '0, 2'b00, 1'b0);
        checkState("flush_empty", 0, 2'b00, 1'b1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
